// File: rtl/cache_axi_bridge_pkg.sv
// Shared definitions for the cache-to-AXI line bridge.
// Holds the read/write FSM state enums, the AXI burst constants, the
// 128-bit cache line type and a line-alignment helper.
package cache_axi_bridge_pkg;

    localparam int          CACHE_LINE_BEATS = 4;        // 32-bit beats per line
    localparam int          CACHE_LINE_BITS  = 128;
    localparam logic [1:0]  BURST_INCR       = 2'b01;
    localparam logic [2:0]  BEAT_SIZE_4B     = 3'b010;   // 4 bytes per beat

    typedef logic [CACHE_LINE_BITS-1:0] line_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA,
        R_DONE
    } rd_state_t;

    typedef enum logic [2:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP,
        W_DONE
    } wr_state_t;

    // Clear the byte offset so the burst starts on a 16-byte line boundary.
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:4], 4'b0000};
    endfunction

endpackage

// File: rtl/cache_line_wr_ctrl.sv
// Cache line write controller: accepts one 128-bit line from the cache and
// writes it out as a 4-beat INCR burst on AXI AW/W/B.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   wr_req/wr_addr/wr_data   - line-write request from the cache
//   wr_rdy                   - controller idle, request may be accepted
//   wr_valid                 - one-cycle pulse when the line write completes
//   awaddr/awvalid/awready   - AXI write address handshake
//   wdata/wlast/wvalid/wready- AXI write data handshake
//   bvalid/bready            - AXI write response handshake (bresp ignored)
//   busy/line_addr           - in-flight line address for the read hazard check
module cache_line_wr_ctrl
    import cache_axi_bridge_pkg::*;
#(
    parameter int LINE_BEATS = CACHE_LINE_BEATS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_req,
    input  logic [31:0] wr_addr,
    input  line_t       wr_data,
    output logic        wr_rdy,
    output logic        wr_valid,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready,
    output logic        busy,
    output logic [27:0] line_addr
);

    localparam logic [1:0] LAST_BEAT = 2'(LINE_BEATS - 1);

    wr_state_t   state, state_next;
    logic [31:0] addr_q;
    line_t       data_q;
    logic [1:0]  beat_cnt;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) state <= W_IDLE;
        else     state <= state_next;
    end

    // NOTE: every always_comb output gets a default first; a path that
    // leaves a signal unassigned would infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            W_IDLE: if (wr_req)                      state_next = W_ADDR;
            W_ADDR: if (awready)                     state_next = W_DATA;
            W_DATA: if (wready && beat_cnt == LAST_BEAT) state_next = W_RESP;
            W_RESP: if (bvalid)                      state_next = W_DONE;
            W_DONE:                                  state_next = W_IDLE;
            default:                                 state_next = W_IDLE;
        endcase
    end

    always_comb begin
        wr_rdy   = 1'b0;
        awvalid  = 1'b0;
        wvalid   = 1'b0;
        wlast    = 1'b0;
        bready   = 1'b0;
        wr_valid = 1'b0;
        unique case (state)
            W_IDLE: wr_rdy = 1'b1;
            W_ADDR: awvalid = 1'b1;
            W_DATA: begin
                wvalid = 1'b1;
                wlast  = (beat_cnt == LAST_BEAT);
            end
            W_RESP: bready = 1'b1;
            W_DONE: wr_valid = 1'b1;
            default: ;
        endcase
    end

    // NOTE: the wide line buffer is reset too, so awaddr/wdata never show
    // X after reset; this buffer is a flop bank, not a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            data_q   <= '0;
            beat_cnt <= '0;
        end else begin
            if (wr_req && wr_rdy) begin
                addr_q   <= line_align(wr_addr);
                data_q   <= wr_data;
                beat_cnt <= '0;
            end else if (state == W_DATA && wready) begin
                beat_cnt <= beat_cnt + 2'd1;
            end
        end
    end

    // Low word first: beat k carries line bits [32k+31:32k].
    assign wdata     = data_q[{beat_cnt, 5'b00000} +: 32];
    assign awaddr    = addr_q;
    assign busy      = (state != W_IDLE);
    assign line_addr = addr_q[31:4];

endmodule

// File: rtl/cache_axi_bridge.sv
// Cache-to-AXI bridge: turns 128-bit cache line reads (and, optionally,
// line writes) into 4-beat INCR bursts of 32-bit AXI beats.
// Configuration: define CACHE_AXI_WRITE_EN to compile in the write path
// (cache_line_wr_ctrl) and the read-after-write line hazard check. Without
// it the write-side handshakes are tied low and reads are unaffected.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   rd_req/rd_addr/rd_rdy             - cache line-read request channel
//   ret_valid/ret_data                - line-read return
//   wr_req/wr_addr/wr_data/wr_rdy     - cache line-write request channel
//   wr_valid                          - line write completed
//   ar*/r*, aw*/w*, b*                - AXI4 master read and write channels
module cache_axi_bridge
    import cache_axi_bridge_pkg::*;
#(
    parameter logic [3:0] AXI_ID     = 4'd0,
    parameter int         LINE_BEATS = CACHE_LINE_BEATS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    output logic        rd_rdy,
    output logic        ret_valid,
    output line_t       ret_data,
    input  logic        wr_req,
    input  logic [31:0] wr_addr,
    input  line_t       wr_data,
    output logic        wr_rdy,
    output logic        wr_valid,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    // Fixed burst shape: one full line per burst, 4-byte beats, incrementing.
    assign arid    = AXI_ID;
    assign arlen   = 8'(LINE_BEATS - 1);
    assign arsize  = BEAT_SIZE_4B;
    assign arburst = BURST_INCR;
    assign awid    = AXI_ID;
    assign awlen   = 8'(LINE_BEATS - 1);
    assign awsize  = BEAT_SIZE_4B;
    assign awburst = BURST_INCR;
    assign wstrb   = 4'hF;

    // ---------------------------------------------------------------- write
    logic        rd_hazard;

`ifdef CACHE_AXI_WRITE_EN
    logic        wr_busy;
    logic [27:0] wr_line;

    cache_line_wr_ctrl #(
        .LINE_BEATS (LINE_BEATS)
    ) u_wr_ctrl (
        .clk       (clk),
        .rst       (rst),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_rdy    (wr_rdy),
        .wr_valid  (wr_valid),
        .awaddr    (awaddr),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wlast     (wlast),
        .wvalid    (wvalid),
        .wready    (wready),
        .bvalid    (bvalid),
        .bready    (bready),
        .busy      (wr_busy),
        .line_addr (wr_line)
    );

    // A read must not overtake a write to the same line: block it while that
    // line is in flight, and also when the write is being accepted this very
    // cycle (the write wins the tie).
    assign rd_hazard = (wr_busy && rd_addr[31:4] == wr_line) ||
                       (wr_req && wr_rdy && rd_addr[31:4] == wr_addr[31:4]);

    logic unused_ok;
    assign unused_ok = ^{rresp, bresp};
`else
    assign wr_rdy    = 1'b0;
    assign wr_valid  = 1'b0;
    assign awaddr    = '0;
    assign awvalid   = 1'b0;
    assign wdata     = '0;
    assign wlast     = 1'b0;
    assign wvalid    = 1'b0;
    assign bready    = 1'b0;
    assign rd_hazard = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{rresp, bresp, bvalid, wr_req, wr_addr, wr_data,
                         awready, wready};
`endif

    // ----------------------------------------------------------------- read
    rd_state_t  r_state, r_next;
    logic [1:0] beat_cnt;

    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE: if (rd_req && rd_rdy)  r_next = R_ADDR;
            R_ADDR: if (arready)           r_next = R_DATA;
            R_DATA: if (rvalid && rlast)   r_next = R_DONE;
            R_DONE:                        r_next = R_IDLE;
            default:                       r_next = R_IDLE;
        endcase
    end

    always_comb begin
        arvalid   = 1'b0;
        rready    = 1'b0;
        ret_valid = 1'b0;
        unique case (r_state)
            R_ADDR:  arvalid   = 1'b1;
            R_DATA:  rready    = 1'b1;
            R_DONE:  ret_valid = 1'b1;
            default: ;
        endcase
    end

    assign rd_rdy = (r_state == R_IDLE) && !rd_hazard;

    // araddr is held from acceptance, so it stays stable while arvalid waits.
    // ret_data keeps the last line until a new read starts filling it.
    always_ff @(posedge clk) begin
        if (rst) begin
            araddr   <= '0;
            beat_cnt <= '0;
            ret_data <= '0;
        end else begin
            if (rd_req && rd_rdy) begin
                araddr   <= line_align(rd_addr);
                beat_cnt <= '0;
            end
            if (r_state == R_DATA && rvalid) begin
                ret_data[{beat_cnt, 5'b00000} +: 32] <= rdata;
                beat_cnt <= beat_cnt + 2'd1;
            end
        end
    end

endmodule

// File: doc/cache_axi_bridge.md
CACHE_AXI_BRIDGE -- requirements
Module: cache_axi_bridge

Interface
REQ-001 SHALL have parameter AXI_ID, default 4'd0, driven on arid/awid.
REQ-002 SHALL have parameter LINE_BEATS, default 4, 32-bit beats per cache line, matching a 128-bit line.
REQ-003 SHALL have clk in 1, the single clock.
REQ-004 SHALL have rst in 1, synchronous active-high reset.
REQ-005 SHALL have cache port rd_req/rd_addr in 1/32 and rd_rdy out 1 (line-read request channel).
REQ-006 SHALL have cache port ret_valid/ret_data out 1/128 (line-read return).
REQ-007 SHALL have cache port wr_req/wr_addr/wr_data in 1/32/128 and wr_rdy out 1 (line-write request channel).
REQ-008 SHALL have cache port wr_valid out 1 (line write completed).
REQ-009 SHALL have AXI AR ports arid/araddr/arlen/arsize/arburst/arvalid out 4/32/8/3/2/1, and arready in 1.
REQ-010 SHALL have AXI R ports rdata/rresp/rlast/rvalid in 32/2/1/1, and rready out 1.
REQ-011 SHALL have AXI AW ports awid/awaddr/awlen/awsize/awburst/awvalid out 4/32/8/3/2/1, and awready in 1.
REQ-012 SHALL have AXI W ports wdata/wstrb/wlast/wvalid out 32/4/1/1, and wready in 1.
REQ-013 SHALL have AXI B ports bresp/bvalid in 2/1, and bready out 1.

Function
REQ-014 SHALL drive arlen/awlen=LINE_BEATS-1, arsize/awsize=3'b010, arburst/awburst=2'b01 (INCR) and wstrb=4'hF as constants.
REQ-015 Read FSM SHALL have states R_IDLE, R_ADDR, R_DATA, R_DONE; rd_rdy=1 only in R_IDLE and only when no hazard exists (REQ-022).
REQ-016 On rd_req&&rd_rdy, SHALL latch {rd_addr[31:4],4'b0} into araddr and enter R_ADDR.
REQ-017 In R_ADDR, arvalid SHALL be 1 and held stable until arready; on arready, SHALL enter R_DATA.
REQ-018 In R_DATA, rready SHALL be 1; each rvalid beat k (2-bit counter, from 0) SHALL be written to ret_data[32k+31:32k].
REQ-019 On the rvalid&&rlast beat, SHALL enter R_DONE; ret_valid SHALL be 1 for exactly one cycle there, then R_IDLE. ret_data SHALL hold its value until the next accepted read. rresp SHALL be ignored.
REQ-020 Read latency: request at cycle 0, arvalid at cycle 1; with arready at 1 and back-to-back beats at 2..5, ret_valid SHALL occur at cycle 6.
REQ-021 Write FSM SHALL have states W_IDLE, W_ADDR, W_DATA, W_RESP, W_DONE; wr_rdy=1 only in W_IDLE; on acceptance it SHALL latch the aligned address and 128-bit data.
REQ-022 Hazard: while the write FSM is not in W_IDLE, rd_rdy SHALL be 0 if rd_addr[31:4] equals the latched write line address.
REQ-023 Sequencing: W_ADDR asserts awvalid until awready. W_DATA sends beats 0..3 low word first, wvalid held until wready, wlast on beat 3. W_RESP asserts bready until bvalid. W_DONE pulses wr_valid for one cycle, then W_IDLE. bresp SHALL be ignored.
REQ-024 The read and write FSMs SHALL be independent; simultaneous rd_req and wr_req to different lines SHALL both be accepted in the same cycle.
REQ-025 Same-line rd_req and wr_req in the same cycle: the write SHALL be accepted, and the read SHALL be stalled until W_DONE completes.

Reset
REQ-026 rst SHALL force both FSMs to idle, counters to 0, ret_data to 0, and all valid/ready outputs to 0 except rd_rdy/wr_rdy, which SHALL be 1 from the first cycle after reset.
REQ-027 Reset mid-burst SHALL abandon the transaction without draining AXI; the system resets the interconnect concurrently.

Configuration
REQ-028 Macro CACHE_AXI_WRITE_EN SHALL compile in the write FSM.
REQ-029 Without CACHE_AXI_WRITE_EN: wr_rdy, wr_valid, awvalid, wvalid, wlast and bready SHALL be tied 0; the hazard check SHALL be disabled; reads SHALL behave identically.

Structure
REQ-030 Read/write state enums, burst constants (INCR, LINE_BEATS) and the 128-bit line type SHALL live in the shared cache package.
REQ-031 The write path SHALL be a sub-module cache_line_wr_ctrl, instantiated under CACHE_AXI_WRITE_EN.

Verification
REQ-032 Read 0x1FC0_0014, arready immediate, rdata 0x11,0x22,0x33,0x44 back-to-back -> araddr=0x1FC0_0010, ret_data=0x00000044_00000033_00000022_00000011, ret_valid at cycle 6.
REQ-033 Read with arready delayed 3 cycles and rvalid gaps -> araddr/arvalid stable throughout, ret_valid one cycle only, correct beat order.
REQ-034 Write 0x8000_0020 with data 0xDDDD..._CCCC..._BBBB..._AAAA..., wready toggling -> wdata AAAA, BBBB, CCCC, DDDD; wlast on the 4th beat only; wr_valid one cycle after bvalid.
REQ-035 Write pending to 0x8000_0020 and read to 0x8000_002C -> rd_rdy=0 until wr_valid; read to 0x8000_0040 is accepted at once.
REQ-036 rst asserted during R_DATA beat 2 -> next cycle rready=0, rd_rdy=1, ret_valid=0, and a following read completes correctly.
